shift_ctrl: RTL and testbench

- Sequencer for the processor's shift datapath: the shift-amount source mux (3-bit selector) and the shift register.
- The main control unit hands it one shift-class instruction (SLL, SRL, SRA, SLLV, SRLV, SRAV, LUI) via a start/op handshake.
- It drives the mux selector, the load-data source select and the shift-register function code, then pulses a write-back enable and done.
- Fixed latency: lets the main FSM stall for exactly a known number of cycles.

---
 rtl/shift_ctrl_pkg.sv | 37 +++
 rtl/shift_ctrl_op_decode.sv | 29 ++
 rtl/shift_ctrl.sv | 126 ++++++++++++
 tb/tb_shift_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/shift_ctrl_pkg.sv
// Shared encodings for the shift-datapath sequencer: op codes, mux selects,
// shift-register function codes and FSM states.
package shift_ctrl_pkg;

  localparam int SEL_W = 3;
  localparam int FN_W  = 3;
  localparam int OP_W  = 3;

  typedef enum logic [OP_W-1:0] {
    OP_SLL  = 3'b000,
    OP_SRL  = 3'b001,
    OP_SRA  = 3'b010,
    OP_SLLV = 3'b011,
    OP_SRLV = 3'b100,
    OP_SRAV = 3'b101,
    OP_LUI  = 3'b110,
    OP_ILL  = 3'b111
  } op_e;

  localparam logic [SEL_W-1:0] AMT_SHAMT = 3'b000;
  localparam logic [SEL_W-1:0] AMT_K16   = 3'b001;
  localparam logic [SEL_W-1:0] AMT_RS    = 3'b010;

  localparam logic [FN_W-1:0] FN_HOLD = 3'b000;
  localparam logic [FN_W-1:0] FN_LOAD = 3'b001;
  localparam logic [FN_W-1:0] FN_LEFT = 3'b010;
  localparam logic [FN_W-1:0] FN_RLOG = 3'b011;
  localparam logic [FN_W-1:0] FN_RARI = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_WB    = 2'b11
  } state_e;

endpackage

// File: rtl/shift_ctrl_op_decode.sv
// Pure decode of a shift op into amount-mux select, load-data source and
// shift direction/function; also usable standalone for disassembly.
module shift_op_decode
  import shift_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  output logic [SEL_W-1:0] amt_sel,
  output logic             data_src,
  output logic [FN_W-1:0]  dir_fn
);

  always_comb begin
    amt_sel  = AMT_SHAMT;
    data_src = 1'b0;
    dir_fn   = FN_HOLD;
    case (op)
      OP_SLL:  begin amt_sel = AMT_SHAMT; dir_fn = FN_LEFT; end
      OP_SRL:  begin amt_sel = AMT_SHAMT; dir_fn = FN_RLOG; end
      OP_SRA:  begin amt_sel = AMT_SHAMT; dir_fn = FN_RARI; end
      OP_SLLV: begin amt_sel = AMT_RS;    dir_fn = FN_LEFT; end
      OP_SRLV: begin amt_sel = AMT_RS;    dir_fn = FN_RLOG; end
      OP_SRAV: begin amt_sel = AMT_RS;    dir_fn = FN_RARI; end
      // LUI is a left shift by 16 of the immediate
      OP_LUI:  begin amt_sel = AMT_K16; data_src = 1'b1; dir_fn = FN_LEFT; end
      default: begin amt_sel = AMT_SHAMT; data_src = 1'b0; dir_fn = FN_HOLD; end
    endcase
  end

endmodule

// File: rtl/shift_ctrl.sv
// Fixed-latency sequencer for the shift datapath: LOAD -> SHIFT -> WB,
// with every output held in a flop so nothing combinational reaches the pins.
module shift_ctrl
  import shift_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  output logic [SEL_W-1:0] amt_sel,
  output logic             data_src,
  output logic [FN_W-1:0]  shift_fn,
  output logic             wr_en,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [SEL_W-1:0] amt_sel_q, amt_sel_d;
  logic             data_src_q, data_src_d;
  logic [FN_W-1:0]  shift_fn_q, shift_fn_d;
  logic             wr_en_q, wr_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [SEL_W-1:0] dec_amt_sel;
  logic             dec_data_src;
  logic [FN_W-1:0]  dec_dir_fn;

  // Decode the op that will be latched after this edge, so the output
  // flops already carry the right values in the first cycle of LOAD.
  shift_op_decode u_decode (
    .op       (op_d),
    .amt_sel  (dec_amt_sel),
    .data_src (dec_data_src),
    .dir_fn   (dec_dir_fn)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_ILL) begin
            err_d = 1'b1;
          end else begin
            op_d    = op;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: state_d = ST_WB;
      ST_WB:    state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    amt_sel_d  = AMT_SHAMT;
    data_src_d = 1'b0;
    shift_fn_d = FN_HOLD;
    wr_en_d    = 1'b0;
    done_d     = 1'b0;
    busy_d     = (state_d != ST_IDLE);
    case (state_d)
      ST_LOAD: begin
        amt_sel_d  = dec_amt_sel;
        data_src_d = dec_data_src;
        shift_fn_d = FN_LOAD;
      end
      ST_SHIFT: begin
        amt_sel_d  = dec_amt_sel;
        data_src_d = dec_data_src;
        shift_fn_d = dec_dir_fn;
      end
      ST_WB: begin
        amt_sel_d  = dec_amt_sel;
        data_src_d = dec_data_src;
        wr_en_d    = 1'b1;
        done_d     = 1'b1;
      end
      default: begin
        amt_sel_d  = AMT_SHAMT;
        data_src_d = 1'b0;
        shift_fn_d = FN_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      amt_sel_q  <= AMT_SHAMT;
      data_src_q <= 1'b0;
      shift_fn_q <= FN_HOLD;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      amt_sel_q  <= amt_sel_d;
      data_src_q <= data_src_d;
      shift_fn_q <= shift_fn_d;
      wr_en_q    <= wr_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign amt_sel  = amt_sel_q;
  assign data_src = data_src_q;
  assign shift_fn = shift_fn_q;
  assign wr_en    = wr_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// Directed bench for shift_ctrl; outputs are packed as
// {amt_sel, data_src, shift_fn, wr_en, busy, done, err} and compared to hand values.
module tb_shift_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [2:0] amt_sel;
  logic       data_src;
  logic [2:0] shift_fn;
  logic       wr_en;
  logic       busy;
  logic       done;
  logic       err;

  int checks;
  int errors;
  int doneCount;
  int wrSeenInReset;

  shift_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .amt_sel  (amt_sel),
    .data_src (data_src),
    .shift_fn (shift_fn),
    .wr_en    (wr_en),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] packOut();
    return {amt_sel, data_src, shift_fn, wr_en, busy, done, err};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // advance one edge and settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [2:0] o);
    start = s;
    op    = o;
  endtask

  task automatic runSeq(input string tag, input logic [2:0] o, input logic [2:0] laterOp,
                        input logic [10:0] expLoad, input logic [10:0] expShift,
                        input logic [10:0] expWb);
    applyStimulus(1'b1, o);
    step();
    checkOutput({tag, "_load"}, 32'(packOut()), 32'(expLoad));
    applyStimulus(1'b0, laterOp);
    step();
    checkOutput({tag, "_shift"}, 32'(packOut()), 32'(expShift));
    step();
    checkOutput({tag, "_wb"}, 32'(packOut()), 32'(expWb));
    step();
    checkOutput({tag, "_idle"}, 32'(packOut()), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    applyStimulus(1'b0, 3'b000);
    step();
    checkOutput("reset_outputs", 32'(packOut()), 32'd0);
    reset = 1'b0;
    step();
    checkOutput("idle_after_reset", 32'(packOut()), 32'd0);

    // SLL: shamt source, rt load, left shift
    runSeq("sll", 3'b000, 3'b000,
           {3'b000, 1'b0, 3'b001, 4'b0100},
           {3'b000, 1'b0, 3'b010, 4'b0100},
           {3'b000, 1'b0, 3'b000, 4'b1110});

    // LUI: constant 16, immediate load, left shift
    runSeq("lui", 3'b110, 3'b000,
           {3'b001, 1'b1, 3'b001, 4'b0100},
           {3'b001, 1'b1, 3'b010, 4'b0100},
           {3'b001, 1'b1, 3'b000, 4'b1110});

    // SRAV with op changed to SLL after acceptance
    runSeq("srav", 3'b101, 3'b000,
           {3'b010, 1'b0, 3'b001, 4'b0100},
           {3'b010, 1'b0, 3'b100, 4'b0100},
           {3'b010, 1'b0, 3'b000, 4'b1110});

    // Illegal op: single err pulse, nothing else moves
    applyStimulus(1'b1, 3'b111);
    step();
    checkOutput("ill_err", 32'(packOut()), 32'(11'b000_0_000_0001));
    applyStimulus(1'b0, 3'b000);
    step();
    checkOutput("ill_err_clear", 32'(packOut()), 32'd0);

    runSeq("srl", 3'b001, 3'b001,
           {3'b000, 1'b0, 3'b001, 4'b0100},
           {3'b000, 1'b0, 3'b011, 4'b0100},
           {3'b000, 1'b0, 3'b000, 4'b1110});

    // start held for 8 edges: accepted at step 1 and step 5 only
    doneCount = 0;
    applyStimulus(1'b1, 3'b001);
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 8) applyStimulus(1'b0, 3'b001);
      checkOutput($sformatf("b2b_done_%0d", i), 32'(done), 32'((i == 3 || i == 7) ? 1 : 0));
      checkOutput($sformatf("b2b_busy_%0d", i), 32'(busy),
                  32'(((i >= 1 && i <= 3) || (i >= 5 && i <= 7)) ? 1 : 0));
      if (done) doneCount++;
    end
    checkOutput("b2b_completions", 32'(doneCount), 32'd2);

    // async reset during SHIFT aborts without a write-back
    wrSeenInReset = 0;
    applyStimulus(1'b1, 3'b000);
    step();
    applyStimulus(1'b0, 3'b000);
    step();
    checkOutput("abort_in_shift", 32'(packOut()), 32'(11'b000_0_010_0100));
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_async_zero", 32'(packOut()), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      if (wr_en) wrSeenInReset++;
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (wr_en) wrSeenInReset++;
    end
    checkOutput("abort_no_wr", 32'(wrSeenInReset), 32'd0);
    checkOutput("abort_idle", 32'(packOut()), 32'd0);

    runSeq("sllv_after_abort", 3'b011, 3'b011,
           {3'b010, 1'b0, 3'b001, 4'b0100},
           {3'b010, 1'b0, 3'b010, 4'b0100},
           {3'b010, 1'b0, 3'b000, 4'b1110});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
